// File: rtl/alu_control_block.sv
// ---------------------------------------------------------------------------
// alu_control_block
//
// Purpose:
//   Translates the main-control operation class (ALUOp), the R-type funct
//   field and the instruction opcode into a 4-bit ALU operation select.
//   It also produces a jump-register indicator. Both outputs are registered,
//   so the decode of the inputs sampled at a rising edge appears one cycle
//   later.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous active-high reset (ALUControl=ADD, JR=0)
//   ALUOp       in   2  00 R-type, 01 branch, 10 load/store, 11 I-type ALU
//   Function    in   6  R-type funct field, instruction bits [5:0]
//   Opcode      in   6  instruction opcode, bits [31:26]
//   ALUControl  out  4  registered ALU operation select
//   JRControl   out  1  registered jump-register indicator
// ---------------------------------------------------------------------------
module alu_control_block (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ALUOp,
    input  logic [5:0] Function,
    input  logic [5:0] Opcode,
    output logic [3:0] ALUControl,
    output logic       JRControl
);

    // ALU operation encodings
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    logic [3:0] w_alu_control;
    logic       w_jr_control;
    logic [3:0] r_alu_control;
    logic       r_jr_control;

    // Funct decode for R-type instructions. JR (funct 8) uses the adder,
    // so anything unrecognised also falls back to ADD.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] code;
        case (funct)
            6'd32, 6'd33: code = ALU_ADD;
            6'd34, 6'd35: code = ALU_SUB;
            6'd36:        code = ALU_AND;
            6'd37:        code = ALU_OR;
            6'd38:        code = ALU_XOR;
            6'd39:        code = ALU_NOR;
            6'd42:        code = ALU_SLT;
            6'd43:        code = ALU_SLTU;
            6'd0:         code = ALU_SLL;
            6'd2:         code = ALU_SRL;
            6'd3:         code = ALU_SRA;
            6'd8:         code = ALU_ADD;
            default:      code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Opcode decode for I-type ALU instructions.
    function automatic logic [3:0] decode_opcode(input logic [5:0] opc);
        logic [3:0] code;
        case (opc)
            6'd8, 6'd9: code = ALU_ADD;
            6'd10:      code = ALU_SLT;
            6'd11:      code = ALU_SLTU;
            6'd12:      code = ALU_AND;
            6'd13:      code = ALU_OR;
            6'd14:      code = ALU_XOR;
            6'd15:      code = ALU_LUI;
            default:    code = ALU_ADD;
        endcase
        return code;
    endfunction

    always_comb begin
        w_alu_control = ALU_ADD;
        w_jr_control  = 1'b0;
        case (ALUOp)
            2'b00: begin
                w_alu_control = decode_funct(Function);
                w_jr_control  = (Function == 6'd8);
            end
            2'b01:   w_alu_control = ALU_SUB;
            2'b10:   w_alu_control = ALU_ADD;
            2'b11:   w_alu_control = decode_opcode(Opcode);
            default: w_alu_control = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_control <= ALU_ADD;
            r_jr_control  <= 1'b0;
        end else begin
            r_alu_control <= w_alu_control;
            r_jr_control  <= w_jr_control;
        end
    end

    assign ALUControl = r_alu_control;
    assign JRControl  = r_jr_control;

endmodule

// File: tb/tb_alu_control_block.sv
// ---------------------------------------------------------------------------
// tb_alu_control_block
//
// Directed vectors with hand-computed expected values. The driver applies
// one vector per cycle on the falling edge and queues the expected registered
// response; a monitor pops one entry after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_alu_control_block;

    logic       clk;
    logic       reset;
    logic [1:0] ALUOp;
    logic [5:0] Function;
    logic [5:0] Opcode;
    logic [3:0] ALUControl;
    logic       JRControl;

    typedef struct {
        logic [3:0] alu;
        logic       jr;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    alu_control_block dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOp      (ALUOp),
        .Function   (Function),
        .Opcode     (Opcode),
        .ALUControl (ALUControl),
        .JRControl  (JRControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector per cycle: inputs change on the falling edge, the expected
    // value is what the register must hold after the next rising edge.
    task automatic drive(input logic rst, input logic [1:0] op,
                         input logic [5:0] fn, input logic [5:0] opc,
                         input logic [3:0] ea, input logic ej,
                         input string nm);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        ALUOp    = op;
        Function = fn;
        Opcode   = opc;
        e.alu  = ea;
        e.jr   = ej;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Inputs changing between edges must not disturb the registered outputs.
    task automatic hold_check(input logic [3:0] ea, input logic ej);
        @(posedge clk);
        #3;
        Function = 6'd36;
        ALUOp    = 2'b00;
        #1;
        checks++;
        if (ALUControl !== ea || JRControl !== ej)
            $display("FAIL hold_between_edges: got alu=%b jr=%b, expected alu=%b jr=%b",
                     ALUControl, JRControl, ea, ej);
        else
            passed++;
    endtask

    // Monitor: compare after every rising edge for which a vector was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ALUControl !== e.alu || JRControl !== e.jr)
                    $display("FAIL %s: got alu=%b jr=%b, expected alu=%b jr=%b",
                             e.name, ALUControl, JRControl, e.alu, e.jr);
                else begin
                    passed++;
                    $display("ok   %s: alu=%b jr=%b", e.name, ALUControl, JRControl);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ALUOp = 2'b00; Function = 6'd0; Opcode = 6'd0;

        // Reset two cycles, then first decode with no dead cycle
        drive(1, 2'b00, 6'd36, 6'd0,  4'b0010, 0, "reset_c1");
        drive(1, 2'b00, 6'd8,  6'd0,  4'b0010, 0, "reset_c2");
        drive(0, 2'b00, 6'd32, 6'd0,  4'b0010, 0, "rtype_add32");
        hold_check(4'b0010, 1'b0);

        // R-type sweep
        drive(0, 2'b00, 6'd36, 6'd0,  4'b0000, 0, "rtype_and");
        drive(0, 2'b00, 6'd37, 6'd0,  4'b0001, 0, "rtype_or");
        drive(0, 2'b00, 6'd39, 6'd0,  4'b1100, 0, "rtype_nor");
        drive(0, 2'b00, 6'd0,  6'd0,  4'b0100, 0, "rtype_sll");
        drive(0, 2'b00, 6'd42, 6'd0,  4'b0111, 0, "rtype_slt");
        drive(0, 2'b00, 6'd34, 6'd0,  4'b0110, 0, "rtype_sub34");
        drive(0, 2'b00, 6'd33, 6'd12, 4'b0010, 0, "rtype_addu33");
        drive(0, 2'b00, 6'd35, 6'd0,  4'b0110, 0, "rtype_subu35");
        drive(0, 2'b00, 6'd38, 6'd0,  4'b0011, 0, "rtype_xor");
        drive(0, 2'b00, 6'd43, 6'd0,  4'b1000, 0, "rtype_sltu");
        drive(0, 2'b00, 6'd2,  6'd0,  4'b0101, 0, "rtype_srl");
        drive(0, 2'b00, 6'd3,  6'd0,  4'b1101, 0, "rtype_sra");
        drive(0, 2'b00, 6'd63, 6'd15, 4'b0010, 0, "rtype_default");

        // Jump register, then funct 8 ignored outside R-type
        drive(0, 2'b00, 6'd8,  6'd0,  4'b0010, 1, "rtype_jr");
        drive(0, 2'b11, 6'd8,  6'd8,  4'b0010, 0, "itype_addi_fn8");

        // I-type
        drive(0, 2'b11, 6'd36, 6'd12, 4'b0000, 0, "itype_andi");
        drive(0, 2'b11, 6'd0,  6'd13, 4'b0001, 0, "itype_ori");
        drive(0, 2'b11, 6'd0,  6'd10, 4'b0111, 0, "itype_slti");
        drive(0, 2'b11, 6'd0,  6'd15, 4'b1001, 0, "itype_lui");
        drive(0, 2'b11, 6'd0,  6'd4,  4'b0010, 0, "itype_default");
        drive(0, 2'b11, 6'd0,  6'd9,  4'b0010, 0, "itype_addiu");
        drive(0, 2'b11, 6'd0,  6'd11, 4'b1000, 0, "itype_sltiu");
        drive(0, 2'b11, 6'd0,  6'd14, 4'b0011, 0, "itype_xori");

        // Branch and load/store ignore Function and Opcode
        drive(0, 2'b01, 6'd8,  6'd15, 4'b0110, 0, "branch_sub");
        drive(0, 2'b10, 6'd8,  6'd12, 4'b0010, 0, "ldst_add");

        // Reset mid-stream overrides decode, held reset holds, release restores
        drive(0, 2'b00, 6'd8,  6'd0,  4'b0010, 1, "jr_before_reset");
        drive(1, 2'b00, 6'd8,  6'd0,  4'b0010, 0, "reset_mid1");
        drive(1, 2'b00, 6'd36, 6'd0,  4'b0010, 0, "reset_mid2");
        drive(0, 2'b00, 6'd8,  6'd0,  4'b0010, 1, "jr_after_reset");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_block.md
ALU_CONTROL_BLOCK -- requirements
Module: alu_control_block

Interface
REQ-001 Parameters: none; all widths and encodings below are fixed.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 ALUOp  input  2  operation class from main control: 00 R-type, 01 branch, 10 load/store, 11 I-type ALU.
REQ-006 Function  input  6  R-type funct field, instruction bits [5:0].
REQ-007 Opcode  input  6  instruction opcode, bits [31:26].
REQ-008 ALUControl  output  4  registered ALU operation select.
REQ-009 JRControl  output  1  registered jump-register indicator.

Function
REQ-010 ALUControl encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, LUI 1001, SRA 1101, NOR 1100.
REQ-011 Both outputs are registered: the value decoded from inputs sampled at rising edge N appears after edge N and holds until edge N+1; latency is 1 cycle.
REQ-012 ALUOp=00 decodes Function: 32/33 ADD; 34/35 SUB; 36 AND; 37 OR; 38 XOR; 39 NOR; 42 SLT; 43 SLTU; 0 SLL; 2 SRL; 3 SRA; 8 ADD.
REQ-013 ALUOp=00 with any other Function value gives ADD (0010).
REQ-014 ALUOp=01 gives SUB (0110), regardless of Function and Opcode.
REQ-015 ALUOp=10 gives ADD (0010), regardless of Function and Opcode.
REQ-016 ALUOp=11 decodes Opcode: 8/9 ADD; 10 SLT; 11 SLTU; 12 AND; 13 OR; 14 XOR; 15 LUI; any other Opcode gives ADD.
REQ-017 JRControl is 1 only when ALUOp=00 and Function=8, otherwise 0.
REQ-018 Function is ignored unless ALUOp=00; Opcode is ignored unless ALUOp=11.
REQ-019 Decode is a pure function of the current sample; no other history or state.
REQ-020 Inputs changing between edges have no effect on outputs until the next rising edge.
REQ-021 X/Z-free inputs always produce a defined 4-bit code; no latches are inferred.

Reset
REQ-022 reset=1 at a rising edge sets ALUControl=0010 and JRControl=0, overriding any decode.
REQ-023 reset has priority over all inputs; while held high, outputs stay at their reset values.
REQ-024 The first edge with reset=0 registers the decode of the inputs at that edge, with no extra dead cycle.
REQ-025 Before the first reset the output values are unspecified; the bench applies reset for at least 1 cycle.

Verification
REQ-026 Reset 2 cycles, then ALUOp=00, Function=32 -> after next edge ALUControl=0010, JRControl=0.
REQ-027 R-type sweep, ALUOp=00: Function 36, 37, 39, 0, 42, 34 -> ALUControl 0000, 0001, 1100, 0100, 0111, 0110, each one cycle after the input is applied.
REQ-028 ALUOp=00, Function=8 -> ALUControl=0010, JRControl=1; next cycle ALUOp=11, Function=8, Opcode=8 -> ALUControl=0010, JRControl=0.
REQ-029 ALUOp=11, Opcode 12, 13, 10, 15, 4 -> ALUControl 0000, 0001, 0111, 1001, 0010; ALUOp=01 -> 0110; ALUOp=10 -> 0010.
REQ-030 Latency/reset check: with ALUOp=00 and Function=8, output JRControl=1; assert reset mid-stream -> at that edge outputs become 0010/0; deassert -> the following edge restores the decode.
